// File: rtl/psram_qpi_dev.sv
// psram_qpi_dev: cycle-based behavioural model of a QSPI PSRAM.
// Recognises SPI-mode enter-QPI (35h), then QPI quad read (EBh), quad write
// (38h) and exit-QPI (F5h) against an internal byte array. The data bus is
// split into in/out/enable so the surrounding bench resolves the inout.
//
// Handshake: there is no valid/ready pair. The controller owns qspi_sck and
// qspi_ce_n; a transfer is a ce_n-low window. Inputs are sampled in the clock
// cycle where a rising SCK edge is seen. Read data is launched in the cycle
// where a falling SCK edge is seen, so it is stable before the next rise.
// ce_n high aborts any transfer at once and discards partial bytes.
module psram_qpi_dev #(
  parameter int AW       = 12,
  parameter int WAIT_CYC = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       qspi_sck,
  input  logic       qspi_ce_n,
  input  logic [3:0] qspi_dio_i,
  output logic [3:0] qspi_dio_o,
  output logic [3:0] qspi_dio_oe,
  output logic       qpi_mode,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_WAIT   = 3'd3,
    S_RDATA  = 3'd4,
    S_WDATA  = 3'd5,
    S_IGNORE = 3'd6
  } state_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(WAIT_CYC - 1);
  localparam logic [7:0] LP_CMD_QPI   = 8'h35;
  localparam logic [7:0] LP_CMD_READ  = 8'hEB;
  localparam logic [7:0] LP_CMD_WRITE = 8'h38;
  localparam logic [7:0] LP_CMD_EXIT  = 8'hF5;

  state_t        r_state;
  logic          r_sck_d;
  logic          r_qpi;
  logic [7:0]    r_cmd;
  logic [7:0]    r_shift;
  logic [7:0]    r_cnt;
  logic [23:0]   r_addr;
  logic          r_nib_lo;   // 0: next nibble is the high half of a byte
  logic [3:0]    r_wr_hi;
  logic [3:0]    r_dio_o;
  logic [3:0]    r_dio_oe;

  // Backing store; contents survive reset and start out as zero.
  logic [7:0]    r_mem [0:(1<<AW)-1] = '{default: 8'h00};

  logic          w_rise;
  logic          w_fall;
  logic [7:0]    w_cmd_next;
  logic          w_cmd_done;
  logic [AW-1:0] w_idx;
  logic [7:0]    w_rd_byte;
  logic          w_mem_we;

  assign w_rise     = qspi_sck & ~r_sck_d;
  assign w_fall     = ~qspi_sck & r_sck_d;
  assign w_cmd_next = r_qpi ? {r_shift[3:0], qspi_dio_i} : {r_shift[6:0], qspi_dio_i[0]};
  assign w_cmd_done = r_qpi ? (r_cnt == 8'd1) : (r_cnt == 8'd7);
  assign w_idx      = r_addr[AW-1:0];
  assign w_rd_byte  = r_mem[w_idx];
  assign w_mem_we   = ~qspi_ce_n & (r_state == S_WDATA) & w_rise & r_nib_lo;

  assign qspi_dio_o  = r_dio_o;
  assign qspi_dio_oe = r_dio_oe;
  assign qpi_mode    = r_qpi;
  assign dbg_state   = r_state;

  // Protocol FSM: edge detect, command/address decode and read data launch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_sck_d  <= 1'b0;
      r_qpi    <= 1'b0;
      r_cmd    <= 8'h00;
      r_shift  <= 8'h00;
      r_cnt    <= 8'h00;
      r_addr   <= 24'h000000;
      r_nib_lo <= 1'b0;
      r_wr_hi  <= 4'h0;
      r_dio_o  <= 4'h0;
      r_dio_oe <= 4'h0;
    end else begin
      r_sck_d <= qspi_sck;
      if (qspi_ce_n) begin
        r_state  <= S_IDLE;
        r_dio_oe <= 4'h0;
        r_dio_o  <= 4'h0;
        r_shift  <= 8'h00;
        r_cnt    <= 8'h00;
        r_nib_lo <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_CMD;
            r_cnt   <= 8'h00;
            r_shift <= 8'h00;
          end
          S_CMD: begin
            if (w_rise) begin
              r_shift <= w_cmd_next;
              r_cnt   <= r_cnt + 8'd1;
              if (w_cmd_done) begin
                r_cmd <= w_cmd_next;
                r_cnt <= 8'h00;
                if (!r_qpi && (w_cmd_next == LP_CMD_QPI)) begin
                  r_qpi   <= 1'b1;
                  r_state <= S_IGNORE;
                end else if (r_qpi && ((w_cmd_next == LP_CMD_READ) ||
                                       (w_cmd_next == LP_CMD_WRITE))) begin
                  r_state <= S_ADDR;
                end else if (r_qpi && (w_cmd_next == LP_CMD_EXIT)) begin
                  r_qpi   <= 1'b0;
                  r_state <= S_IGNORE;
                end else begin
                  r_state <= S_IGNORE;
                end
              end
            end
          end
          S_ADDR: begin
            if (w_rise) begin
              r_addr <= {r_addr[19:0], qspi_dio_i};
              r_cnt  <= r_cnt + 8'd1;
              if (r_cnt == 8'd5) begin
                r_cnt    <= 8'h00;
                r_nib_lo <= 1'b0;
                if (r_cmd == LP_CMD_READ) begin
                  r_state <= (WAIT_CYC == 0) ? S_RDATA : S_WAIT;
                end else begin
                  r_state <= S_WDATA;
                end
              end
            end
          end
          S_WAIT: begin
            if (w_rise) begin
              r_cnt <= r_cnt + 8'd1;
              if (r_cnt == LP_WAIT_LAST) begin
                r_cnt   <= 8'h00;
                r_state <= S_RDATA;
              end
            end
          end
          S_RDATA: begin
            if (w_fall) begin
              r_dio_oe <= 4'hF;
              r_dio_o  <= r_nib_lo ? w_rd_byte[3:0] : w_rd_byte[7:4];
              r_nib_lo <= ~r_nib_lo;
              if (r_nib_lo) begin
                r_addr <= r_addr + 24'd1;
              end
            end
          end
          S_WDATA: begin
            if (w_rise) begin
              if (!r_nib_lo) begin
                r_wr_hi  <= qspi_dio_i;
                r_nib_lo <= 1'b1;
              end else begin
                r_addr   <= r_addr + 24'd1;
                r_nib_lo <= 1'b0;
              end
            end
          end
          S_IGNORE: begin
            r_dio_oe <= 4'h0;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Byte write on the second nibble of each write-data pair.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= {r_wr_hi, qspi_dio_i};
    end
  end

endmodule

// File: tb/tb_psram_qpi_dev.sv
// Bench for psram_qpi_dev: acts as the QSPI controller, keeps a byte-array
// model of the memory plus the expected QPI mode, and compares reads.
module tb_psram_qpi_dev;

  localparam int AW       = 12;
  localparam int WAIT_CYC = 6;
  localparam int DEPTH    = 1 << AW;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sck   = 1'b0;
  logic       ce_n  = 1'b1;
  logic [3:0] dio_i = 4'h0;
  logic [3:0] dio_o;
  logic [3:0] dio_oe;
  logic       qpi_mode;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int oe_cnt   = 0;

  logic [7:0] mdl_mem [0:DEPTH-1];
  bit         mdl_qpi = 1'b0;
  logic [7:0] wr_q[$];
  logic [7:0] rd_q[$];
  int         oe_bad;

  psram_qpi_dev #(.AW(AW), .WAIT_CYC(WAIT_CYC)) dut (
    .clock       (clock),
    .reset       (reset),
    .qspi_sck    (sck),
    .qspi_ce_n   (ce_n),
    .qspi_dio_i  (dio_i),
    .qspi_dio_o  (dio_o),
    .qspi_dio_oe (dio_oe),
    .qpi_mode    (qpi_mode),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // count every sampled cycle in which the model drives the bus
  always @(negedge clock) begin
    if (dio_oe !== 4'h0) oe_cnt <= oe_cnt + 1;
  end

  function automatic logic [AW-1:0] midx(input logic [23:0] a);
    return a[AW-1:0];
  endfunction

  // driver tasks
  task automatic clk_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic sck_cycle(input logic [3:0] nib, output logic [3:0] rd, output logic [3:0] oe);
    dio_i = nib;
    clk_n(2);
    rd  = dio_o;
    oe  = dio_oe;
    sck = 1'b1;
    clk_n(2);
    sck = 1'b0;
  endtask

  task automatic cs_begin();
    ce_n = 1'b0;
    clk_n(2);
  endtask

  task automatic cs_end();
    clk_n(2);
    ce_n  = 1'b1;
    dio_i = 4'h0;
    clk_n(3);
  endtask

  task automatic send_spi_byte(input logic [7:0] b);
    logic [3:0] rd, oe;
    for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]}, rd, oe);
  endtask

  task automatic send_qpi_byte(input logic [7:0] b);
    logic [3:0] rd, oe;
    sck_cycle(b[7:4], rd, oe);
    sck_cycle(b[3:0], rd, oe);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [3:0] rd, oe;
    for (int i = 5; i >= 0; i--) sck_cycle(a[i*4 +: 4], rd, oe);
  endtask

  task automatic enter_qpi();
    cs_begin();
    send_spi_byte(8'h35);
    cs_end();
    mdl_qpi = 1'b1;
  endtask

  // writes wr_q starting at a; optional trailing lone nibble
  task automatic qpi_write(input logic [23:0] a, input bit extra, input logic [3:0] extra_nib);
    logic [3:0] rd, oe;
    cs_begin();
    send_qpi_byte(8'h38);
    send_addr(a);
    foreach (wr_q[i]) send_qpi_byte(wr_q[i]);
    if (extra) sck_cycle(extra_nib, rd, oe);
    cs_end();
    if (mdl_qpi) begin
      foreach (wr_q[i]) mdl_mem[midx(a + 24'(i))] = wr_q[i];
    end
  endtask

  // reads n bytes from a into rd_q; oe_bad counts data nibbles not driven
  task automatic qpi_read(input logic [23:0] a, input int n);
    logic [3:0] hi, lo, oe;
    rd_q.delete();
    oe_bad = 0;
    cs_begin();
    send_qpi_byte(8'hEB);
    send_addr(a);
    for (int i = 0; i < WAIT_CYC; i++) sck_cycle(4'h0, hi, oe);
    for (int i = 0; i < n; i++) begin
      sck_cycle(4'h0, hi, oe);
      if (oe !== 4'hF) oe_bad++;
      sck_cycle(4'h0, lo, oe);
      if (oe !== 4'hF) oe_bad++;
      rd_q.push_back({hi, lo});
    end
    cs_end();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clk_n(3);
    checks++;
    if (qpi_mode !== 1'b0) begin failures++; $display("FAIL reset_qpi: got %b expected 0", qpi_mode); end
    checks++;
    if (dio_oe !== 4'h0) begin failures++; $display("FAIL reset_oe: got %h expected 0", dio_oe); end
    checks++;
    if (dio_o !== 4'h0) begin failures++; $display("FAIL reset_dio: got %h expected 0", dio_o); end
    reset = 1'b1;
    clk_n(2);
  endtask

  task automatic test_enter_qpi();
    int o0;
    o0 = oe_cnt;
    enter_qpi();
    checks++;
    if (qpi_mode !== 1'b1) begin failures++; $display("FAIL enter_qpi: got %b expected 1", qpi_mode); end
    checks++;
    if (oe_cnt != o0) begin failures++; $display("FAIL enter_qpi_oe: got %0d driven cycles expected 0", oe_cnt - o0); end
  endtask

  task automatic test_basic_write_read();
    int o0;
    logic [7:0] exp_b;
    o0 = oe_cnt;
    wr_q = '{8'h12, 8'h34};
    qpi_write(24'h000010, 1'b0, 4'h0);
    checks++;
    if (oe_cnt != o0) begin failures++; $display("FAIL write_oe: got %0d driven cycles expected 0", oe_cnt - o0); end
    qpi_read(24'h000010, 2);
    for (int i = 0; i < 2; i++) begin
      exp_b = mdl_mem[midx(24'h000010 + 24'(i))];
      checks++;
      if (rd_q[i] !== exp_b) begin failures++; $display("FAIL basic_read[%0d]: got %h expected %h", i, rd_q[i], exp_b); end
    end
    checks++;
    if (oe_bad != 0) begin failures++; $display("FAIL read_oe_data: got %0d undriven nibbles expected 0", oe_bad); end
    checks++;
    if (dio_oe !== 4'h0) begin failures++; $display("FAIL read_oe_after: got %h expected 0", dio_oe); end
  endtask

  task automatic test_wrap();
    logic [23:0] addrs [3];
    logic [7:0] exp_b;
    wr_q = '{8'hAA, 8'h55};
    qpi_write(24'h000FFF, 1'b0, 4'h0);
    addrs = '{24'h000000, 24'h001000, 24'h001FFF};
    foreach (addrs[k]) begin
      qpi_read(addrs[k], 1);
      exp_b = mdl_mem[midx(addrs[k])];
      checks++;
      if (rd_q[0] !== exp_b) begin failures++; $display("FAIL wrap_read@%h: got %h expected %h", addrs[k], rd_q[0], exp_b); end
    end
  endtask

  task automatic test_partial_write();
    logic [7:0] exp_b;
    wr_q = '{8'h98};
    qpi_write(24'h000020, 1'b1, 4'h7);
    qpi_read(24'h000020, 2);
    for (int i = 0; i < 2; i++) begin
      exp_b = mdl_mem[midx(24'h000020 + 24'(i))];
      checks++;
      if (rd_q[i] !== exp_b) begin failures++; $display("FAIL partial_write[%0d]: got %h expected %h", i, rd_q[i], exp_b); end
    end
  endtask

  task automatic test_unknown_cmd();
    int o0;
    logic [3:0] rd, oe;
    o0 = oe_cnt;
    cs_begin();
    send_qpi_byte(8'h9F);
    for (int i = 0; i < 10; i++) sck_cycle(4'(i), rd, oe);
    cs_end();
    checks++;
    if (oe_cnt != o0) begin failures++; $display("FAIL unknown_cmd_oe: got %0d driven cycles expected 0", oe_cnt - o0); end
    checks++;
    if (qpi_mode !== 1'b1) begin failures++; $display("FAIL unknown_cmd_qpi: got %b expected 1", qpi_mode); end
  endtask

  task automatic test_random();
    logic [23:0] a;
    int len;
    bit extra;
    logic [7:0] exp_b;
    for (int it = 0; it < 8; it++) begin
      a     = 24'($urandom);
      len   = $urandom_range(1, 4);
      extra = 1'($urandom_range(0, 1));
      wr_q.delete();
      for (int j = 0; j < len; j++) wr_q.push_back(8'($urandom_range(0, 255)));
      qpi_write(a, extra, 4'($urandom_range(0, 15)));
      qpi_read(a, len + 1);
      for (int j = 0; j <= len; j++) begin
        exp_b = mdl_mem[midx(a + 24'(j))];
        checks++;
        if (rd_q[j] !== exp_b) begin failures++; $display("FAIL random_read it%0d[%0d]@%h: got %h expected %h", it, j, a, rd_q[j], exp_b); end
      end
    end
  endtask

  task automatic test_exit_qpi();
    cs_begin();
    send_qpi_byte(8'hF5);
    cs_end();
    mdl_qpi = 1'b0;
    checks++;
    if (qpi_mode !== 1'b0) begin failures++; $display("FAIL exit_qpi: got %b expected 0", qpi_mode); end
    enter_qpi();
    checks++;
    if (qpi_mode !== 1'b1) begin failures++; $display("FAIL reenter_qpi: got %b expected 1", qpi_mode); end
  endtask

  task automatic test_reset_mid_read();
    logic [3:0] rd, oe;
    int o0;
    logic [7:0] exp_b;
    wr_q = '{8'hC3, 8'h5A};
    qpi_write(24'h000040, 1'b0, 4'h0);
    cs_begin();
    send_qpi_byte(8'hEB);
    send_addr(24'h000040);
    for (int i = 0; i < WAIT_CYC; i++) sck_cycle(4'h0, rd, oe);
    sck_cycle(4'h0, rd, oe);
    sck_cycle(4'h0, rd, oe);
    clk_n(2);
    reset = 1'b0;
    #1;
    mdl_qpi = 1'b0;
    checks++;
    if (dio_oe !== 4'h0) begin failures++; $display("FAIL midread_reset_oe: got %h expected 0", dio_oe); end
    checks++;
    if (dio_o !== 4'h0) begin failures++; $display("FAIL midread_reset_dio: got %h expected 0", dio_o); end
    checks++;
    if (qpi_mode !== 1'b0) begin failures++; $display("FAIL midread_reset_qpi: got %b expected 0", qpi_mode); end
    clk_n(1);
    ce_n = 1'b1;
    clk_n(2);
    reset = 1'b1;
    clk_n(2);
    o0 = oe_cnt;
    qpi_read(24'h000010, 2);
    checks++;
    if (oe_cnt != o0) begin failures++; $display("FAIL spi_mode_read_oe: got %0d driven cycles expected 0", oe_cnt - o0); end
    checks++;
    if (qpi_mode !== 1'b0) begin failures++; $display("FAIL spi_mode_read_qpi: got %b expected 0", qpi_mode); end
    enter_qpi();
    qpi_read(24'h000040, 2);
    for (int i = 0; i < 2; i++) begin
      exp_b = mdl_mem[midx(24'h000040 + 24'(i))];
      checks++;
      if (rd_q[i] !== exp_b) begin failures++; $display("FAIL mem_kept[%0d]: got %h expected %h", i, rd_q[i], exp_b); end
    end
  endtask

  // watchdog: the bench must always reach its summary line
  initial begin
    #5ms;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
    test_reset();
    test_enter_qpi();
    test_basic_write_read();
    test_wrap();
    test_partial_write();
    test_unknown_cmd();
    test_random();
    test_exit_qpi();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
